// File: rtl/instruction_fetch_stage.sv
// instruction_fetch_stage
//   IF stage of a 5-stage MIPS pipeline. Holds the PC and a debug-loadable
//   instruction memory, selects the next PC (sequential / jump / branch) and
//   detects HALT. A LOAD/RUN/HALTED FSM gates fetching for the debug unit.
// Ports
//   clk, rst         clock (posedge) and asynchronous active-high reset
//   i_enable         debug run/step enable; 0 freezes PC, FSM and memory
//   i_start          LOAD -> RUN request
//   i_is_write_pc    hazard unit; 0 holds the PC
//   i_branch_taken   branch resolved taken, target i_branch_addr
//   i_jump           jump decoded, target i_jump_addr
//   i_mem_wr_*       program-load write port (honoured only in LOAD)
//   o_pc             PC + 4 for the IF/ID latch
//   o_pc_current     current PC for debug readout
//   o_instruction    fetched word (NOP_WORD while in LOAD)
//   o_halted         high while the FSM sits in HALTED
module instruction_fetch_stage #(
  parameter int unsigned MEM_DEPTH = 256,
  parameter int unsigned ADDR_W    = 8,
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF,
  parameter logic [31:0] NOP_WORD  = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_enable,
  input  logic              i_start,
  input  logic              i_is_write_pc,
  input  logic              i_branch_taken,
  input  logic [31:0]       i_branch_addr,
  input  logic              i_jump,
  input  logic [31:0]       i_jump_addr,
  input  logic              i_mem_wr_en,
  input  logic [ADDR_W-1:0] i_mem_wr_addr,
  input  logic [31:0]       i_mem_wr_data,
  output logic [31:0]       o_pc,
  output logic [31:0]       o_pc_current,
  output logic [31:0]       o_instruction,
  output logic              o_halted
);

  typedef enum logic [1:0] {StLoad, StRun, StHalted} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] mem_q [MEM_DEPTH];

  logic [ADDR_W-1:0] fetch_idx;
  logic [31:0]       fetch_word;

  // Word index drops the byte offset; upper PC bits wrap modulo MEM_DEPTH.
  assign fetch_idx  = pc_q[ADDR_W+1:2];
  assign fetch_word = mem_q[fetch_idx];

  // Memory clear is synchronous: it completes on the first edge with rst high.
  // Fetch output is forced to NOP in LOAD, so the stale contents are never seen.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < MEM_DEPTH; i++) begin
        mem_q[i] <= NOP_WORD;
      end
    end else if (i_enable && (state_q == StLoad) && i_mem_wr_en) begin
      mem_q[i_mem_wr_addr] <= i_mem_wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StLoad;
      pc_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    if (i_enable) begin
      unique case (state_q)
        StLoad: begin
          pc_d = 32'd0;
          if (i_start) state_d = StRun;
        end
        StRun: begin
          // Redirects beat both the stall and HALT: a redirect flushes the HALT.
          if (i_branch_taken) begin
            pc_d = i_branch_addr & ~32'h3;
          end else if (i_jump) begin
            pc_d = i_jump_addr & ~32'h3;
          end else if (!i_is_write_pc) begin
            pc_d = pc_q;
          end else if (fetch_word == HALT_WORD) begin
            pc_d    = pc_q;
            state_d = StHalted;
          end else begin
            pc_d = pc_q + 32'd4;
          end
        end
        StHalted: begin
          pc_d = pc_q;
        end
        default: begin
          state_d = StLoad;
          pc_d    = 32'd0;
        end
      endcase
    end
  end

  assign o_pc          = pc_q + 32'd4;
  assign o_pc_current  = pc_q;
  assign o_instruction = (state_q == StLoad) ? NOP_WORD : fetch_word;
  assign o_halted      = (state_q == StHalted);

endmodule

// File: tb/tb_instruction_fetch_stage.sv
module tb_instruction_fetch_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        i_enable = 1'b1;
  logic        i_start = 1'b0;
  logic        i_is_write_pc = 1'b1;
  logic        i_branch_taken = 1'b0;
  logic [31:0] i_branch_addr = 32'd0;
  logic        i_jump = 1'b0;
  logic [31:0] i_jump_addr = 32'd0;
  logic        i_mem_wr_en = 1'b0;
  logic [7:0]  i_mem_wr_addr = 8'd0;
  logic [31:0] i_mem_wr_data = 32'd0;
  logic [31:0] o_pc, o_pc_current, o_instruction;
  logic        o_halted;

  int n_cmp = 0;
  int n_err = 0;

  instruction_fetch_stage dut (
    .clk            (clk),
    .rst            (rst),
    .i_enable       (i_enable),
    .i_start        (i_start),
    .i_is_write_pc  (i_is_write_pc),
    .i_branch_taken (i_branch_taken),
    .i_branch_addr  (i_branch_addr),
    .i_jump         (i_jump),
    .i_jump_addr    (i_jump_addr),
    .i_mem_wr_en    (i_mem_wr_en),
    .i_mem_wr_addr  (i_mem_wr_addr),
    .i_mem_wr_data  (i_mem_wr_data),
    .o_pc           (o_pc),
    .o_pc_current   (o_pc_current),
    .o_instruction  (o_instruction),
    .o_halted       (o_halted)
  );

  always #5 clk = ~clk;

  // Stimulus helpers (no checking inside).
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    i_enable = 1'b1; i_start = 1'b0; i_is_write_pc = 1'b1; i_branch_taken = 1'b0;
    i_jump = 1'b0; i_mem_wr_en = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic load_word(input logic [7:0] a, input logic [31:0] d, input logic st);
    i_mem_wr_en = 1'b1; i_mem_wr_addr = a; i_mem_wr_data = d; i_start = st;
    tick();
    i_mem_wr_en = 1'b0; i_start = 1'b0;
  endtask

  task automatic start_run();
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (o_pc_current !== 32'd0) begin n_err++;
      $display("FAIL reset_pc_current got %h exp %h", o_pc_current, 32'd0); end
    n_cmp++; if (o_pc !== 32'd4) begin n_err++;
      $display("FAIL reset_pc got %h exp %h", o_pc, 32'd4); end
    n_cmp++; if (o_instruction !== 32'd0) begin n_err++;
      $display("FAIL reset_instr got %h exp %h", o_instruction, 32'd0); end
    n_cmp++; if (o_halted !== 1'b0) begin n_err++;
      $display("FAIL reset_halted got %b exp 0", o_halted); end
  endtask

  task automatic test_program_halt();
    do_reset();
    load_word(8'd0, 32'h2008_0005, 1'b0);
    load_word(8'd1, 32'h2009_0003, 1'b0);
    load_word(8'd2, 32'hFFFF_FFFF, 1'b0);
    n_cmp++; if (o_instruction !== 32'd0) begin n_err++;
      $display("FAIL load_nop_out got %h exp %h", o_instruction, 32'd0); end
    start_run();
    n_cmp++; if (o_pc !== 32'd4 || o_instruction !== 32'h2008_0005) begin n_err++;
      $display("FAIL prog_w0 got pc %h ins %h exp 4 20080005", o_pc, o_instruction); end
    tick();
    n_cmp++; if (o_pc !== 32'd8 || o_instruction !== 32'h2009_0003) begin n_err++;
      $display("FAIL prog_w1 got pc %h ins %h exp 8 20090003", o_pc, o_instruction); end
    tick();
    n_cmp++; if (o_pc !== 32'd12 || o_instruction !== 32'hFFFF_FFFF || o_halted !== 1'b0)
      begin n_err++; $display("FAIL prog_w2 got pc %h ins %h h %b exp c ffffffff 0",
        o_pc, o_instruction, o_halted); end
    tick();
    n_cmp++; if (o_halted !== 1'b1 || o_pc_current !== 32'd8) begin n_err++;
      $display("FAIL halt_enter got h %b pc %h exp 1 8", o_halted, o_pc_current); end
    i_branch_taken = 1'b1; i_branch_addr = 32'h40; i_start = 1'b1;
    tick(); tick();
    i_branch_taken = 1'b0; i_start = 1'b0;
    n_cmp++; if (o_halted !== 1'b1 || o_pc_current !== 32'd8 || o_instruction !== 32'hFFFF_FFFF)
      begin n_err++; $display("FAIL halt_frozen got h %b pc %h ins %h exp 1 8 ffffffff",
        o_halted, o_pc_current, o_instruction); end
    // Reset must also wipe the HALT word loaded above.
    do_reset();
    start_run();
    tick(); tick();
    n_cmp++; if (o_pc_current !== 32'd8 || o_instruction !== 32'd0 || o_halted !== 1'b0)
      begin n_err++; $display("FAIL mem_cleared got pc %h ins %h h %b exp 8 0 0",
        o_pc_current, o_instruction, o_halted); end
  endtask

  task automatic test_branch();
    do_reset();
    start_run();
    i_branch_taken = 1'b1; i_branch_addr = 32'h10;
    tick();
    n_cmp++; if (o_pc_current !== 32'h10) begin n_err++;
      $display("FAIL branch_10 got %h exp %h", o_pc_current, 32'h10); end
    i_branch_addr = 32'h40;
    tick();
    n_cmp++; if (o_pc_current !== 32'h40 || o_pc !== 32'h44) begin n_err++;
      $display("FAIL branch_40 got %h/%h exp 40/44", o_pc_current, o_pc); end
    i_branch_addr = 32'h63;
    tick();
    i_branch_taken = 1'b0;
    n_cmp++; if (o_pc_current !== 32'h60) begin n_err++;
      $display("FAIL branch_align got %h exp %h", o_pc_current, 32'h60); end
  endtask

  task automatic test_priority();
    do_reset();
    start_run();
    i_jump = 1'b1; i_jump_addr = 32'h80; i_branch_taken = 1'b1; i_branch_addr = 32'h20;
    tick();
    i_branch_taken = 1'b0;
    n_cmp++; if (o_pc_current !== 32'h20) begin n_err++;
      $display("FAIL branch_over_jump got %h exp %h", o_pc_current, 32'h20); end
    i_jump_addr = 32'h86;
    tick();
    i_jump = 1'b0;
    n_cmp++; if (o_pc_current !== 32'h84) begin n_err++;
      $display("FAIL jump_only got %h exp %h", o_pc_current, 32'h84); end
  endtask

  task automatic test_stall();
    do_reset();
    start_run();
    tick(); tick();
    i_is_write_pc = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_cmp++; if (o_pc_current !== 32'h8) begin n_err++;
        $display("FAIL stall_hold_%0d got %h exp %h", k, o_pc_current, 32'h8); end
    end
    i_branch_taken = 1'b1; i_branch_addr = 32'h30;
    tick();
    i_branch_taken = 1'b0;
    n_cmp++; if (o_pc_current !== 32'h30) begin n_err++;
      $display("FAIL stall_branch got %h exp %h", o_pc_current, 32'h30); end
    i_jump = 1'b1; i_jump_addr = 32'h50;
    tick();
    i_jump = 1'b0;
    n_cmp++; if (o_pc_current !== 32'h50) begin n_err++;
      $display("FAIL stall_jump got %h exp %h", o_pc_current, 32'h50); end
    i_is_write_pc = 1'b1;
    tick();
    n_cmp++; if (o_pc_current !== 32'h54) begin n_err++;
      $display("FAIL stall_release got %h exp %h", o_pc_current, 32'h54); end
  endtask

  task automatic test_halt_flush();
    do_reset();
    load_word(8'd0, 32'hFFFF_FFFF, 1'b0);
    start_run();
    i_branch_taken = 1'b1; i_branch_addr = 32'h0;
    tick();
    i_branch_taken = 1'b0;
    n_cmp++; if (o_pc_current !== 32'h0 || o_halted !== 1'b0) begin n_err++;
      $display("FAIL halt_flushed got pc %h h %b exp 0 0", o_pc_current, o_halted); end
    i_is_write_pc = 1'b0;
    tick();
    n_cmp++; if (o_pc_current !== 32'h0 || o_halted !== 1'b0) begin n_err++;
      $display("FAIL halt_stalled got pc %h h %b exp 0 0", o_pc_current, o_halted); end
    i_is_write_pc = 1'b1;
    tick();
    n_cmp++; if (o_halted !== 1'b1 || o_pc_current !== 32'h0) begin n_err++;
      $display("FAIL halt_after_stall got h %b pc %h exp 1 0", o_halted, o_pc_current); end
  endtask

  task automatic test_enable();
    do_reset();
    i_enable = 1'b0;
    load_word(8'd0, 32'hDEAD_BEEF, 1'b1);
    i_enable = 1'b1;
    n_cmp++; if (o_instruction !== 32'd0 || o_pc_current !== 32'd0) begin n_err++;
      $display("FAIL en0_load got ins %h pc %h exp 0 0", o_instruction, o_pc_current); end
    start_run();
    n_cmp++; if (o_instruction !== 32'd0) begin n_err++;
      $display("FAIL en0_no_write got %h exp %h", o_instruction, 32'd0); end
    i_enable = 1'b0; i_branch_taken = 1'b1; i_branch_addr = 32'h40;
    tick();
    n_cmp++; if (o_pc_current !== 32'h0) begin n_err++;
      $display("FAIL en0_freeze got %h exp %h", o_pc_current, 32'h0); end
    i_enable = 1'b1;
    tick();
    i_branch_taken = 1'b0;
    n_cmp++; if (o_pc_current !== 32'h40) begin n_err++;
      $display("FAIL en1_resume got %h exp %h", o_pc_current, 32'h40); end
  endtask

  task automatic test_run_write_reset();
    do_reset();
    load_word(8'd1, 32'h1111_1111, 1'b0);
    start_run();
    i_mem_wr_en = 1'b1; i_mem_wr_addr = 8'd1; i_mem_wr_data = 32'h2222_2222;
    tick();
    i_mem_wr_en = 1'b0;
    n_cmp++; if (o_pc_current !== 32'd4 || o_instruction !== 32'h1111_1111) begin n_err++;
      $display("FAIL run_write_ignored got pc %h ins %h exp 4 11111111",
        o_pc_current, o_instruction); end
    tick();
    rst = 1'b1;
    #1;
    n_cmp++; if (o_pc_current !== 32'd0 || o_pc !== 32'd4 || o_instruction !== 32'd0 ||
      o_halted !== 1'b0) begin n_err++;
      $display("FAIL async_rst got pc %h npc %h ins %h h %b exp 0 4 0 0",
        o_pc_current, o_pc, o_instruction, o_halted); end
    tick();
    rst = 1'b0;
    start_run();
    tick();
    n_cmp++; if (o_pc_current !== 32'd4 || o_instruction !== 32'd0) begin n_err++;
      $display("FAIL rst_mem_clear got pc %h ins %h exp 4 0", o_pc_current, o_instruction); end
  endtask

  task automatic test_wrap();
    do_reset();
    load_word(8'd255, 32'h5555_AAAA, 1'b0);
    load_word(8'd0, 32'hABCD_0001, 1'b1);
    n_cmp++; if (o_instruction !== 32'hABCD_0001 || o_pc_current !== 32'd0) begin n_err++;
      $display("FAIL write_with_start got ins %h pc %h exp abcd0001 0",
        o_instruction, o_pc_current); end
    i_branch_taken = 1'b1; i_branch_addr = 32'h3FC;
    tick();
    i_branch_taken = 1'b0;
    n_cmp++; if (o_instruction !== 32'h5555_AAAA || o_pc !== 32'h400) begin n_err++;
      $display("FAIL wrap_top got ins %h npc %h exp 5555aaaa 400", o_instruction, o_pc); end
    tick();
    n_cmp++; if (o_pc_current !== 32'h400 || o_instruction !== 32'hABCD_0001) begin n_err++;
      $display("FAIL wrap_idx0 got pc %h ins %h exp 400 abcd0001",
        o_pc_current, o_instruction); end
    i_branch_taken = 1'b1; i_branch_addr = 32'hFFFF_FFFF;
    tick();
    i_branch_taken = 1'b0;
    n_cmp++; if (o_pc_current !== 32'hFFFF_FFFC || o_pc !== 32'd0 ||
      o_instruction !== 32'h5555_AAAA) begin n_err++;
      $display("FAIL pc32_wrap got pc %h npc %h ins %h exp fffffffc 0 5555aaaa",
        o_pc_current, o_pc, o_instruction); end
  endtask

  initial begin
    test_reset();
    test_program_halt();
    test_branch();
    test_priority();
    test_stall();
    test_halt_flush();
    test_enable();
    test_run_write_reset();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
